// File: rtl/tone_decoder.sv
// Buzzer PWM receive-side decoder: measures the falling-edge period, classifies it to a note code and reports stable note changes.
// Optional input deglitch filter enabled by defining TONE_DEC_GLITCH_EN.
module tone_decoder #(
  parameter int CLK_PRE     = 50_000_000,
  parameter int SILENCE_CYC = 1_000_000,
`ifdef TONE_DEC_GLITCH_EN
  parameter int GLITCH_CYC  = 4,
`endif
  parameter int STABLE_N    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwm_in,
  output logic [4:0]  note_code,
  output logic        note_valid,
  output logic [23:0] note_dur,
  output logic [19:0] period
);

  localparam int              MW       = $clog2(STABLE_N + 1);
  localparam logic [19:0]     SIL      = 20'(SILENCE_CYC);
  localparam logic [MW-1:0]   STABLE   = MW'(STABLE_N);
  localparam logic [4:0]      CODE_UNK = 5'd31;
  localparam logic [4:0]      IDX_END  = 5'd25;
  localparam logic [23:0]     DUR_MAX  = '1;

  typedef enum logic [1:0] {SILENT, ARM, LOOKUP, DECIDE} state_t;

  function automatic logic [19:0] nom_period(input logic [4:0] idx);
    case (idx)
      5'd1:    nom_period = 20'(CLK_PRE / 262);
      5'd2:    nom_period = 20'(CLK_PRE / 294);
      5'd3:    nom_period = 20'(CLK_PRE / 330);
      5'd4:    nom_period = 20'(CLK_PRE / 349);
      5'd5:    nom_period = 20'(CLK_PRE / 392);
      5'd6:    nom_period = 20'(CLK_PRE / 440);
      5'd7:    nom_period = 20'(CLK_PRE / 494);
      5'd8:    nom_period = 20'(CLK_PRE / 523);
      5'd9:    nom_period = 20'(CLK_PRE / 587);
      5'd10:   nom_period = 20'(CLK_PRE / 659);
      5'd11:   nom_period = 20'(CLK_PRE / 698);
      5'd12:   nom_period = 20'(CLK_PRE / 740);
      5'd13:   nom_period = 20'(CLK_PRE / 784);
      5'd14:   nom_period = 20'(CLK_PRE / 831);
      5'd15:   nom_period = 20'(CLK_PRE / 880);
      5'd16:   nom_period = 20'(CLK_PRE / 932);
      5'd17:   nom_period = 20'(CLK_PRE / 988);
      5'd18:   nom_period = 20'(CLK_PRE / 1046);
      5'd19:   nom_period = 20'(CLK_PRE / 1175);
      5'd20:   nom_period = 20'(CLK_PRE / 1318);
      5'd21:   nom_period = 20'(CLK_PRE / 1397);
      5'd22:   nom_period = 20'(CLK_PRE / 1568);
      5'd23:   nom_period = 20'(CLK_PRE / 1760);
      5'd24:   nom_period = 20'(CLK_PRE / 1976);
      default: nom_period = '0;
    endcase
  endfunction

  state_t        state, state_next;
  logic          sync1, sync2, level, level_prev, fall, silence;
  logic [19:0]   count, count_p1, p_reg, pend_p, p_val, nom, diff;
  logic [4:0]    idx, idx_next, cand, prev_cand, cand_val, commit_code;
  logic [MW-1:0] match_cnt, match_new;
  logic [23:0]   dur_cnt, dur_p1;
  logic          pending, hit, p_load, pend_set, pend_clr, cand_load;
  logic          do_decide, do_silence, commit;

  // Idle-high line: synchronizer resets to 1 so reset release never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
    end
  end

`ifdef TONE_DEC_GLITCH_EN
  localparam int GW = $clog2(GLITCH_CYC + 1);
  logic          filt;
  logic [GW-1:0] gcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= 1'b1;
      gcnt <= '0;
    end else if (sync2 == filt) begin
      gcnt <= '0;
    end else if (gcnt == GW'(GLITCH_CYC - 1)) begin
      filt <= sync2;
      gcnt <= '0;
    end else begin
      gcnt <= gcnt + 1'b1;
    end
  end
  assign level = filt;
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_prev <= 1'b1;
    else        level_prev <= level;
  end

  assign fall     = level_prev & ~level;
  assign silence  = (count >= SIL) && !fall;
  // The edge cycle itself belongs to the period, hence the +1 on capture.
  assign count_p1 = (count == '1) ? count : count + 20'd1;
  assign dur_p1   = (dur_cnt == DUR_MAX) ? dur_cnt : dur_cnt + 24'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          count <= '0;
    else if (fall)       count <= '0;
    else if (count < SIL) count <= count + 20'd1;
  end

  always_comb begin
    nom  = nom_period(idx);
    diff = (p_reg >= nom) ? p_reg - nom : nom - p_reg;
    hit  = (diff <= (nom >> 6));
  end

  always_comb begin
    if (cand == prev_cand) match_new = (match_cnt >= STABLE) ? STABLE : match_cnt + 1'b1;
    else                   match_new = MW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SILENT;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    idx_next    = idx;
    p_load      = 1'b0;
    p_val       = count_p1;
    pend_set    = 1'b0;
    pend_clr    = 1'b0;
    cand_load   = 1'b0;
    cand_val    = idx;
    do_decide   = 1'b0;
    do_silence  = 1'b0;
    case (state)
      SILENT: if (fall) state_next = ARM;
      ARM: begin
        if (fall) begin
          p_load     = 1'b1;
          idx_next   = 5'd1;
          state_next = LOOKUP;
        end else if (silence) begin
          do_silence = 1'b1;
          state_next = SILENT;
        end
      end
      LOOKUP: begin
        if (fall) pend_set = 1'b1;
        if (silence) begin
          do_silence = 1'b1;
          pend_clr   = 1'b1;
          state_next = SILENT;
        end else if (idx == IDX_END) begin
          cand_load  = 1'b1;
          cand_val   = CODE_UNK;
          state_next = DECIDE;
        end else if (hit) begin
          cand_load  = 1'b1;
          state_next = DECIDE;
        end else begin
          idx_next = idx + 5'd1;
        end
      end
      DECIDE: begin
        do_decide = 1'b1;
        pend_clr  = 1'b1;
        if (fall || pending) begin
          p_load     = 1'b1;
          p_val      = fall ? count_p1 : pend_p;
          idx_next   = 5'd1;
          state_next = LOOKUP;
        end else begin
          state_next = ARM;
        end
      end
      default: state_next = SILENT;
    endcase
    commit      = (do_decide && match_new == STABLE && cand != note_code) ||
                  (do_silence && note_code != 5'd0);
    commit_code = do_silence ? 5'd0 : cand;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      p_reg      <= '0;
      pend_p     <= '0;
      pending    <= 1'b0;
      cand       <= '0;
      prev_cand  <= '0;
      match_cnt  <= '0;
      note_code  <= '0;
      note_valid <= 1'b0;
      note_dur   <= '0;
      dur_cnt    <= '0;
    end else begin
      idx <= idx_next;
      if (p_load) p_reg <= p_val;
      if (pend_set) begin
        pending <= 1'b1;
        pend_p  <= count_p1;
      end else if (pend_clr) begin
        pending <= 1'b0;
      end
      if (cand_load) cand <= cand_val;
      if (do_silence) begin
        match_cnt <= '0;
        prev_cand <= '0;
      end else if (do_decide) begin
        match_cnt <= match_new;
        prev_cand <= cand;
      end
      note_valid <= commit;
      // Duration reported counts every cycle the outgoing code was visible.
      if (commit) begin
        note_code <= commit_code;
        note_dur  <= dur_p1;
        dur_cnt   <= '0;
      end else begin
        dur_cnt <= dur_p1;
      end
    end
  end

  assign period = p_reg;

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder: scaled clock so notes, silence, jitter, reset and glitch cases fit a short run.
module tb_tone_decoder;
  localparam int CLK_PRE = 2_000_000;
  localparam int SIL     = 8000;
  localparam int LOW     = 71;
  localparam int T_LA    = 2272;
  localparam int T_SO    = 2551;
  localparam int T_SO1   = 2406;
  localparam int T_UNK   = 1800;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pwm_in = 1'b1;
  logic [4:0]  note_code;
  logic        note_valid;
  logic [23:0] note_dur;
  logic [19:0] period;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobes = 0;
  int last_code = 0;
  int last_dur = 0;
  int strobe_cyc = 0;
  int fall_cyc = 0;
  int la_cyc, lat_la, s0, waited, last_edge;

  tone_decoder #(.CLK_PRE(CLK_PRE), .SILENCE_CYC(SIL)) dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
    .note_code(note_code), .note_valid(note_valid),
    .note_dur(note_dur), .period(period)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (note_valid) begin
      strobes    <= strobes + 1;
      last_code  <= note_code;
      last_dur   <= note_dur;
      strobe_cyc <= cyc;
      $display("strobe: code=%0d dur=%0d period=%0d cycle=%0d", note_code, note_dur, period, cyc);
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wave(input int t, input int n, input bit jit);
    for (int i = 0; i < n; i++) begin
      int tt;
      tt = t;
      if (jit) tt = (i % 2 == 0) ? t + 1 : t - 1;
      fall_cyc = cyc;
      pwm_in = 1'b0;
      repeat (LOW) @(negedge clk);
      pwm_in = 1'b1;
      repeat (tt - LOW) @(negedge clk);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_code", note_code, 0);
    chk("rst_valid", note_valid, 0);
    chk("rst_dur", note_dur, 0);
    chk("rst_period", period, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // LA: commit only once the 4th edge has been decided
    wave(T_LA, 3, 1'b0);
    chk("la_no_early", strobes, 0);
    wave(T_LA, 1, 1'b0);
    chk("la_strobe", strobes, 1);
    chk("la_code", note_code, 15);
    chk("la_period", period, 2272);
    la_cyc = strobe_cyc;
    lat_la = strobe_cyc - fall_cyc;
    wave(T_LA, 2, 1'b0);
    chk("la_hold", strobes, 1);

    // silence after the last edge
    s0 = strobes;
    last_edge = fall_cyc;
    waited = 0;
    while (strobes == s0 && waited < SIL + 100) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    chk("sil_strobe", strobes, s0 + 1);
    chk("sil_code", note_code, 0);
    chk("sil_last_code", last_code, 0);
    chk("sil_dur", last_dur, strobe_cyc - la_cyc);
    chk("sil_delay_in_window",
        ((strobe_cyc - last_edge) >= SIL) && ((strobe_cyc - last_edge) <= SIL + 10), 1);

    // SO then SO1 mid-stream
    s0 = strobes;
    wave(T_SO, 4, 1'b0);
    chk("so_strobe", strobes, s0 + 1);
    chk("so_code", note_code, 13);
    s0 = strobes;
    wave(T_SO1, 3, 1'b0);
    chk("so1_no_early", strobes, s0);
    chk("so1_still_so", note_code, 13);
    wave(T_SO1, 1, 1'b0);
    chk("so1_strobe", strobes, s0 + 1);
    chk("so1_code", last_code, 14);

    // unrecognised period, full-length lookup
    s0 = strobes;
    wave(T_UNK, 3, 1'b0);
    chk("unk_no_early", strobes, s0);
    wave(T_UNK, 1, 1'b0);
    chk("unk_strobe", strobes, s0 + 1);
    chk("unk_code", note_code, 31);
    chk("unk_lookup_extra", (strobe_cyc - fall_cyc) - lat_la, 10);

    // jittered LA: one commit, no extra strobes
    s0 = strobes;
    wave(T_LA, 6, 1'b1);
    chk("jit_strobes", strobes, s0 + 1);
    chk("jit_code", note_code, 15);
    chk("jit_period", period, 2273);

    // reset mid-tone
    pwm_in = 1'b0;
    repeat (LOW) @(negedge clk);
    pwm_in = 1'b1;
    repeat (500) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_code", note_code, 0);
    chk("mid_rst_valid", note_valid, 0);
    chk("mid_rst_dur", note_dur, 0);
    chk("mid_rst_period", period, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    s0 = strobes;
    wave(T_LA, 3, 1'b0);
    chk("post_rst_no_early", strobes, s0);
    wave(T_LA, 1, 1'b0);
    chk("post_rst_strobe", strobes, s0 + 1);
    chk("post_rst_code", note_code, 15);

    // 2-cycle high glitch inside a low pulse
    s0 = strobes;
    fall_cyc = cyc;
    pwm_in = 1'b0;
    repeat (20) @(negedge clk);
    pwm_in = 1'b1;
    repeat (2) @(negedge clk);
    pwm_in = 1'b0;
    repeat (LOW - 22) @(negedge clk);
    pwm_in = 1'b1;
    repeat (T_LA - LOW) @(negedge clk);
`ifdef TONE_DEC_GLITCH_EN
    chk("glitch_period", period, 2272);
`else
    chk("glitch_period", period, 22);
`endif
    wave(T_LA, 3, 1'b0);
    chk("glitch_no_strobe", strobes, s0);
    chk("glitch_code", note_code, 15);
    chk("glitch_period_after", period, 2272);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
